// File: rtl/reg_cmd_ctrl_if.sv
// ---------------------------------------------------------------------------
// reg_cmd_ctrl_if
// Purpose : Bundles the UART byte stream, the register-file access signals
//           and the UART transmit handshake used by reg_cmd_ctrl.
// Signals :
//   RX_P_DATA / RX_D_VLD    received UART byte and its one-cycle strobe
//   RdData / RdData_Valid   register-file read data and its strobe
//   TX_BUSY                 UART transmitter busy
//   WrEn / RdEn             register-file write / read enables
//   Address / WrData        register-file address and write data
//   TX_P_DATA / TX_D_VLD    byte to transmit and its one-cycle strobe
//   CMD_ERR                 one-cycle command error pulse
// Modports: slave = the controller, master = the surrounding system.
// ---------------------------------------------------------------------------
interface reg_cmd_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
);
    logic [WIDTH-1:0]      RX_P_DATA;
    logic                  RX_D_VLD;
    logic [WIDTH-1:0]      RdData;
    logic                  RdData_Valid;
    logic                  TX_BUSY;
    logic                  WrEn;
    logic                  RdEn;
    logic [DEPTH_BITS-1:0] Address;
    logic [WIDTH-1:0]      WrData;
    logic [WIDTH-1:0]      TX_P_DATA;
    logic                  TX_D_VLD;
    logic                  CMD_ERR;

    modport slave (
        input  RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
        output WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );

    modport master (
        output RX_P_DATA, RX_D_VLD, RdData, RdData_Valid, TX_BUSY,
        input  WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, CMD_ERR
    );
endinterface

// File: rtl/reg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// reg_cmd_ctrl
// Purpose : Decodes a UART byte stream into register-file commands.
//           AA <addr> <data> writes a register; BB <addr> reads a register
//           and sends the value back through the UART transmitter.
//           Malformed commands, out-of-range addresses, bytes arriving while
//           a command is executing, and a missing read response all produce
//           a one-cycle CMD_ERR pulse. Every output is registered.
// Ports   :
//   CLK   clock, rising edge
//   RST   asynchronous active-low reset
//   bus   reg_cmd_ctrl_if.slave carrying the RX, register-file and TX signals
// ---------------------------------------------------------------------------
module reg_cmd_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_BITS = 4
) (
    input  logic           CLK,
    input  logic           RST,
    reg_cmd_ctrl_if.slave  bus
);

    localparam logic [WIDTH-1:0] CMD_WRITE = WIDTH'(8'hAA);
    localparam logic [WIDTH-1:0] CMD_READ  = WIDTH'(8'hBB);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        WR_EXEC,
        RD_ADDR,
        RD_EXEC,
        RD_WAIT,
        TX_SEND
    } state_t;

    state_t                state_q, state_d;
    logic                  wrEn_q, wrEn_d;
    logic                  rdEn_q, rdEn_d;
    logic                  txVld_q, txVld_d;
    logic                  cmdErr_q, cmdErr_d;
    logic [DEPTH_BITS-1:0] address_q, address_d;
    logic [WIDTH-1:0]      wrData_q, wrData_d;
    logic [WIDTH-1:0]      txData_q, txData_d;
    logic [WIDTH-1:0]      hold_q, hold_d;
    logic [1:0]            waitCnt_q, waitCnt_d;
    logic                  addrInRange;

    // An address byte is legal only when every bit above the address field
    // is zero, i.e. byte < 2**DEPTH_BITS.
    assign addrInRange = ((bus.RX_P_DATA >> DEPTH_BITS) == '0);

    // State and output registers. Reset clears everything, including the
    // read hold register, without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            wrEn_q    <= 1'b0;
            rdEn_q    <= 1'b0;
            txVld_q   <= 1'b0;
            cmdErr_q  <= 1'b0;
            address_q <= '0;
            wrData_q  <= '0;
            txData_q  <= '0;
            hold_q    <= '0;
            waitCnt_q <= '0;
        end else begin
            state_q   <= state_d;
            wrEn_q    <= wrEn_d;
            rdEn_q    <= rdEn_d;
            txVld_q   <= txVld_d;
            cmdErr_q  <= cmdErr_d;
            address_q <= address_d;
            wrData_q  <= wrData_d;
            txData_q  <= txData_d;
            hold_q    <= hold_d;
            waitCnt_q <= waitCnt_d;
        end
    end

    // Next-state and next-output logic. Outputs are computed one cycle ahead
    // and registered, so a strobe decided on an edge appears in the cycle
    // the FSM spends in the matching state. Strobes default low; data
    // registers default to holding their value between transactions.
    always_comb begin
        state_d   = state_q;
        wrEn_d    = 1'b0;
        rdEn_d    = 1'b0;
        txVld_d   = 1'b0;
        cmdErr_d  = 1'b0;
        address_d = address_q;
        wrData_d  = wrData_q;
        txData_d  = txData_q;
        hold_d    = hold_q;
        waitCnt_d = waitCnt_q;

        case (state_q)
            IDLE: begin
                if (bus.RX_D_VLD) begin
                    if (bus.RX_P_DATA == CMD_WRITE) begin
                        state_d = WR_ADDR;
                    end else if (bus.RX_P_DATA == CMD_READ) begin
                        state_d = RD_ADDR;
                    end else begin
                        cmdErr_d = 1'b1;
                    end
                end
            end

            WR_ADDR, RD_ADDR: begin
                if (bus.RX_D_VLD) begin
                    if (addrInRange) begin
                        address_d = bus.RX_P_DATA[DEPTH_BITS-1:0];
                        if (state_q == WR_ADDR) begin
                            state_d = WR_DATA;
                        end else begin
                            state_d = RD_EXEC;
                            rdEn_d  = 1'b1;
                        end
                    end else begin
                        cmdErr_d = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end

            WR_DATA: begin
                if (bus.RX_D_VLD) begin
                    wrData_d = bus.RX_P_DATA;
                    wrEn_d   = 1'b1;
                    state_d  = WR_EXEC;
                end
            end

            // In the executing states a new byte is an overrun: it is
            // dropped and flagged, and the command carries on untouched.
            WR_EXEC: begin
                cmdErr_d = bus.RX_D_VLD;
                state_d  = IDLE;
            end

            RD_EXEC: begin
                cmdErr_d  = bus.RX_D_VLD;
                waitCnt_d = '0;
                state_d   = RD_WAIT;
            end

            // waitCnt_q counts RD_WAIT cycles already spent; the fourth
            // cycle without a response is the last chance. Overrun and
            // timeout share the single error strobe, so they merge.
            RD_WAIT: begin
                cmdErr_d = bus.RX_D_VLD;
                if (bus.RdData_Valid) begin
                    hold_d  = bus.RdData;
                    state_d = TX_SEND;
                end else if (waitCnt_q == 2'd3) begin
                    cmdErr_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 2'd1;
                end
            end

            TX_SEND: begin
                cmdErr_d = bus.RX_D_VLD;
                if (!bus.TX_BUSY) begin
                    txData_d = hold_q;
                    txVld_d  = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.WrEn      = wrEn_q;
    assign bus.RdEn      = rdEn_q;
    assign bus.TX_D_VLD  = txVld_q;
    assign bus.CMD_ERR   = cmdErr_q;
    assign bus.Address   = address_q;
    assign bus.WrData    = wrData_q;
    assign bus.TX_P_DATA = txData_q;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_reg_cmd_ctrl
// Purpose : Self-checking bench for reg_cmd_ctrl. Each directed command task
//           writes the expected output timeline into per-cycle tables from
//           the command protocol timings; a compare process checks every
//           output against those tables on every falling edge, and a few
//           literal checks pin the tables to hand-computed values.
// ---------------------------------------------------------------------------
module tb_reg_cmd_ctrl;

    localparam int MAXC = 1024;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    reg_cmd_ctrl_if #(.WIDTH(8), .DEPTH_BITS(4)) bus ();

    reg_cmd_ctrl #(.WIDTH(8), .DEPTH_BITS(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    // Expected output timeline, one entry per clock cycle.
    bit         expWr   [MAXC];
    bit         expRd   [MAXC];
    bit         expTx   [MAXC];
    bit         expErr  [MAXC];
    logic [3:0] expAddr [MAXC];
    logic [7:0] expWrDat[MAXC];
    logic [7:0] expTxDat[MAXC];

    // Stand-in register file answering reads.
    logic [7:0] mem [16];

    // Cycle k is the interval that starts at the k-th rising edge.
    always @(posedge CLK) cyc <= cyc + 1;

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Drives every input for the next cycle, just after its rising edge.
    task automatic applyStimulus(input logic v, input logic [7:0] b, input logic rv,
                                 input logic [7:0] rd, input logic busy);
        @(posedge CLK);
        #1;
        bus.RX_D_VLD     = v;
        bus.RX_P_DATA    = b;
        bus.RdData_Valid = rv;
        bus.RdData       = rd;
        bus.TX_BUSY      = busy;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic setAddr(input int c, input logic [3:0] v);
        for (int i = c; i < MAXC; i++) expAddr[i] = v;
    endtask

    task automatic setWrData(input int c, input logic [7:0] v);
        for (int i = c; i < MAXC; i++) expWrDat[i] = v;
    endtask

    task automatic setTxData(input int c, input logic [7:0] v);
        for (int i = c; i < MAXC; i++) expTxDat[i] = v;
    endtask

    // Write AA,a,d starting at cycle c0: Address visible from c0+2, WrEn and
    // WrData at c0+3. Returns at the falling edge of cycle c0+3.
    task automatic doWrite(input logic [3:0] a, input logic [7:0] d);
        int c0;
        applyStimulus(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
        c0 = cyc;
        setAddr(c0 + 2, a);
        setWrData(c0 + 3, d);
        expWr[c0 + 3] = 1'b1;
        mem[a] = d;
        applyStimulus(1'b1, {4'h0, a}, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b1, d, 1'b0, 8'h00, 1'b0);
        idleCycle();
        @(negedge CLK);
    endtask

    // Single bad byte in IDLE: error one cycle later.
    task automatic badCmd(input logic [7:0] b);
        int c0;
        applyStimulus(1'b1, b, 1'b0, 8'h00, 1'b0);
        c0 = cyc;
        expErr[c0 + 1] = 1'b1;
        idleCycle();
        @(negedge CLK);
    endtask

    // AA followed by an out-of-range address: error at c0+2, Address kept.
    task automatic writeBadAddr(input logic [7:0] a);
        int c0;
        applyStimulus(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
        c0 = cyc;
        expErr[c0 + 2] = 1'b1;
        applyStimulus(1'b1, a, 1'b0, 8'h00, 1'b0);
        idleCycle();
        @(negedge CLK);
    endtask

    // Read BB,a with BB at cycle c0 and the address byte at N = c0+1.
    // d >= 0: RdData_Valid at N+2+d; TX_BUSY high for b cycles from the
    // first TX_SEND cycle N+3+d; TX_D_VLD at N+4+d+b. d < 0: no response,
    // four waiting cycles N+2..N+5, error at N+6. ovr >= 0 puts a stray
    // byte at relative cycle ovr, flagged one cycle later. Returns at the
    // falling edge of the TX_D_VLD / error cycle.
    task automatic doRead(input logic [3:0] a, input int d, input int b, input int ovr);
        int c0;
        int last;
        applyStimulus(1'b1, 8'hBB, 1'b0, 8'h00, 1'b0);
        c0 = cyc;
        expRd[c0 + 2] = 1'b1;
        setAddr(c0 + 2, a);
        if (d >= 0) begin
            last = 5 + d + b;
            expTx[c0 + last] = 1'b1;
            setTxData(c0 + last, mem[a]);
        end else begin
            last = 7;
            expErr[c0 + 7] = 1'b1;
        end
        if (ovr >= 0) expErr[c0 + ovr + 1] = 1'b1;
        for (int k = 1; k <= last; k++) begin
            logic       v;
            logic [7:0] byteVal;
            logic       rv;
            logic       busy;
            v       = (k == 1) || (k == ovr);
            byteVal = (k == 1) ? {4'h0, a} : (v ? 8'h99 : 8'h00);
            rv      = (d >= 0) && (k == 3 + d);
            busy    = (d >= 0) && (k >= 4 + d) && (k < 4 + d + b);
            applyStimulus(v, byteVal, rv, rv ? mem[a] : 8'hEE, busy);
        end
        @(negedge CLK);
    endtask

    // AA,03 then reset in the middle of the write: every output and the
    // hold register clear immediately. Returns in the cycle RST is released.
    task automatic resetMidWrite();
        int c0;
        applyStimulus(1'b1, 8'hAA, 1'b0, 8'h00, 1'b0);
        c0 = cyc;
        setAddr(c0 + 2, 4'h0);
        setWrData(c0 + 2, 8'h00);
        setTxData(c0 + 2, 8'h00);
        applyStimulus(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
        idleCycle();
        RST = 1'b0;
        idleCycle();
        idleCycle();
        RST = 1'b1;
        @(negedge CLK);
    endtask

    // Every falling edge: all outputs against the expected timeline.
    always @(negedge CLK) begin
        if (cyc < MAXC) begin
            checkOutput("WrEn",      32'(bus.WrEn),      32'(expWr[cyc]));
            checkOutput("RdEn",      32'(bus.RdEn),      32'(expRd[cyc]));
            checkOutput("TX_D_VLD",  32'(bus.TX_D_VLD),  32'(expTx[cyc]));
            checkOutput("CMD_ERR",   32'(bus.CMD_ERR),   32'(expErr[cyc]));
            checkOutput("Address",   32'(bus.Address),   32'(expAddr[cyc]));
            checkOutput("WrData",    32'(bus.WrData),    32'(expWrDat[cyc]));
            checkOutput("TX_P_DATA", 32'(bus.TX_P_DATA), 32'(expTxDat[cyc]));
        end
    end

    // Hard time limit so the bench always ends with a summary.
    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Directed command sequence with literal checks after each step.
    initial begin
        RST              = 1'b0;
        bus.RX_D_VLD     = 1'b0;
        bus.RX_P_DATA    = 8'h00;
        bus.RdData_Valid = 1'b0;
        bus.RdData       = 8'h00;
        bus.TX_BUSY      = 1'b0;
        for (int i = 0; i < MAXC; i++) begin
            expAddr[i]  = 4'h0;
            expWrDat[i] = 8'h00;
            expTxDat[i] = 8'h00;
        end
        for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i);

        repeat (3) idleCycle();
        RST = 1'b1;
        @(negedge CLK);
        $display("[TB] reset state");
        checkOutput("lit_reset_WrEn",    32'(bus.WrEn),      32'h0);
        checkOutput("lit_reset_TXdata",  32'(bus.TX_P_DATA), 32'h0);
        checkOutput("lit_reset_Address", 32'(bus.Address),   32'h0);

        $display("[TB] write AA,03,5C");
        doWrite(4'h3, 8'h5C);
        checkOutput("lit_wr_WrEn",    32'(bus.WrEn),    32'h1);
        checkOutput("lit_wr_Address", 32'(bus.Address), 32'h3);
        checkOutput("lit_wr_WrData",  32'(bus.WrData),  32'h5C);

        $display("[TB] read BB,03 minimum latency");
        doRead(4'h3, 0, 0, -1);
        checkOutput("lit_rd_TXvld",  32'(bus.TX_D_VLD),  32'h1);
        checkOutput("lit_rd_TXdata", 32'(bus.TX_P_DATA), 32'h5C);

        $display("[TB] read with TX_BUSY high for 10 cycles");
        doRead(4'h3, 0, 10, -1);
        checkOutput("lit_bp_TXvld",  32'(bus.TX_D_VLD),  32'h1);
        checkOutput("lit_bp_TXdata", 32'(bus.TX_P_DATA), 32'h5C);

        $display("[TB] bad command byte 0x12");
        badCmd(8'h12);
        checkOutput("lit_bad_CMD_ERR", 32'(bus.CMD_ERR), 32'h1);

        $display("[TB] AA with address 0x10");
        writeBadAddr(8'h10);
        checkOutput("lit_badaddr_CMD_ERR", 32'(bus.CMD_ERR), 32'h1);
        checkOutput("lit_badaddr_Address", 32'(bus.Address), 32'h3);

        $display("[TB] read timeout with overrun in the same cycle");
        doRead(4'h5, -1, 0, 6);
        checkOutput("lit_to_CMD_ERR", 32'(bus.CMD_ERR),   32'h1);
        checkOutput("lit_to_TXdata",  32'(bus.TX_P_DATA), 32'h5C);

        $display("[TB] read with overrun byte during RD_WAIT");
        doRead(4'h7, 2, 1, 3);
        checkOutput("lit_ovr_TXdata", 32'(bus.TX_P_DATA), 32'h37);

        $display("[TB] read address 15 with the latest allowed response");
        doRead(4'hF, 3, 0, -1);
        checkOutput("lit_late_TXdata",  32'(bus.TX_P_DATA), 32'h3F);
        checkOutput("lit_late_Address", 32'(bus.Address),   32'hF);

        $display("[TB] back-to-back writes");
        doWrite(4'h0, 8'hA5);
        doWrite(4'hF, 8'hC3);
        checkOutput("lit_b2b_WrData", 32'(bus.WrData), 32'hC3);

        $display("[TB] reset in the middle of a write");
        resetMidWrite();
        checkOutput("lit_rst_Address", 32'(bus.Address),   32'h0);
        checkOutput("lit_rst_TXdata",  32'(bus.TX_P_DATA), 32'h0);
        doWrite(4'h1, 8'hFF);
        checkOutput("lit_post_Address", 32'(bus.Address), 32'h1);
        checkOutput("lit_post_WrData",  32'(bus.WrData),  32'hFF);

        $display("[TB] read back address 1");
        doRead(4'h1, 1, 0, -1);
        checkOutput("lit_post_TXdata", 32'(bus.TX_P_DATA), 32'hFF);

        repeat (4) idleCycle();
        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
